// File: rtl/seg_scan_recorder_if.sv
// Signal bundle between the page counter / control logic and the
// seg_scan_recorder display driver.
//
// Protocol: there is no valid/ready handshake. The driver samples value and
// hex_mode as levels. While it is idle, any difference from the last captured
// pair starts a conversion, and busy stays high until the display register
// holds the new number. Changes made while busy are picked up once the
// converter returns to idle.
interface seg_scan_recorder_if #(
   parameter int NUM_DIGITS = 8,
   parameter int VALUE_W    = 14
);
   logic [VALUE_W-1:0]    value;
   logic                  ena;
   logic                  hex_mode;
   logic                  blank_lz;
   logic                  blink;
   logic [6:0]            seg_LED;
   logic [NUM_DIGITS-1:0] seg_select;
   logic                  busy;
   logic                  overflow;
   logic [1:0]            conv_state;   // converter state, for observation only

   modport master (
      output value, ena, hex_mode, blank_lz, blink,
      input  seg_LED, seg_select, busy, overflow, conv_state
   );

   modport slave (
      input  value, ena, hex_mode, blank_lz, blink,
      output seg_LED, seg_select, busy, overflow, conv_state
   );
endinterface

// File: rtl/seg_scan_recorder.sv
// Multiplexed 7-segment display driver. A binary value goes through a
// sequential double-dabble converter, or is loaded directly as hex nibbles.
// The result is shown on NUM_DIGITS active-low digits. When TAG_EN is set,
// the upper four digits carry a fixed "PAGE" tag.
module seg_scan_recorder #(
   parameter int NUM_DIGITS = 8,
   parameter int TAG_EN     = 1,
   parameter int VALUE_W    = 14,
   parameter int CLK_DIV    = 80000,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                clk100mhz,
   input  logic                rst,
   seg_scan_recorder_if.slave  bus
);

   function automatic logic [63:0] pow_of(input int base, input int e);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < e; i++) r = r * 64'(base);
      return r;
   endfunction

   function automatic int dec_digits(input int w);
      logic [63:0] v;
      int          n;
      v = (64'd1 << w) - 64'd1;
      n = 1;
      while (v >= 64'd10) begin
         v = v / 64'd10;
         n = n + 1;
      end
      return n;
   endfunction

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'h40;  4'h1: hex_glyph = 7'h79;
         4'h2: hex_glyph = 7'h24;  4'h3: hex_glyph = 7'h30;
         4'h4: hex_glyph = 7'h19;  4'h5: hex_glyph = 7'h12;
         4'h6: hex_glyph = 7'h02;  4'h7: hex_glyph = 7'h78;
         4'h8: hex_glyph = 7'h00;  4'h9: hex_glyph = 7'h10;
         4'hA: hex_glyph = 7'h08;  4'hB: hex_glyph = 7'h03;
         4'hC: hex_glyph = 7'h46;  4'hD: hex_glyph = 7'h21;
         4'hE: hex_glyph = 7'h06;  default: hex_glyph = 7'h0E;
      endcase
   endfunction

   // Tag position 0 is the lowest tag digit ("E"); position 3 is the leftmost ("P").
   function automatic logic [6:0] tag_glyph(input int pos);
      case (pos)
         0:       tag_glyph = 7'h06;
         1:       tag_glyph = 7'h10;
         2:       tag_glyph = 7'h08;
         default: tag_glyph = 7'h0C;
      endcase
   endfunction

   localparam int ND     = (TAG_EN != 0) ? NUM_DIGITS - 4 : NUM_DIGITS;
   localparam int NDA    = (ND > 0) ? ND : 1;
   localparam int BCD_D  = dec_digits(VALUE_W);
   localparam int HEX_D  = (VALUE_W + 3) / 4;
   localparam int ACC_D0 = (BCD_D > HEX_D) ? BCD_D : HEX_D;
   localparam int ACC_D  = (ACC_D0 > NDA) ? ACC_D0 : NDA;
   localparam int ACC_W  = 4 * ACC_D;
   localparam int CNT_W  = $clog2(VALUE_W + 1);
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int DIG_W  = $clog2(NUM_DIGITS);
   localparam logic [63:0] DEC_LIM = pow_of(10, ND);
   localparam logic [63:0] HEX_LIM = pow_of(16, ND);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } conv_state_t;

   conv_state_t           state_q, state_d;
   logic [VALUE_W-1:0]    cap_val_q, cap_val_d;
   logic                  cap_hex_q, cap_hex_d;
   logic [VALUE_W-1:0]    sh_q, sh_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  ovf_q, ovf_d;
   logic [NDA*4-1:0]      num_q, num_d;
   logic                  vld_q, vld_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [DIG_W-1:0]      dig_q, dig_d;
   logic [BLK_W-1:0]      blk_q, blk_d;
   logic                  phase_q, phase_d;
   logic [6:0]            led_q, led_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;

   logic [ACC_W-1:0]      adj;
   logic [NDA-1:0]        keep;
   logic                  any_nz;
   logic [3:0]            nib;
   logic                  kp;
   logic                  is_tag;
   logic [6:0]            tag_g;
   logic [6:0]            glyph;

   // Converter: capture on change, double-dabble (or direct hex load), then commit.
   // An invalid display register (after reset) also starts a conversion.
   always_comb begin
      state_d   = state_q;
      cap_val_d = cap_val_q;
      cap_hex_d = cap_hex_q;
      sh_d      = sh_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      ovf_d     = ovf_q;
      num_d     = num_q;
      vld_d     = vld_q;
      adj       = acc_q;
      for (int i = 0; i < ACC_D; i++) begin
         if (acc_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
      end
      case (state_q)
         ST_IDLE: begin
            if (!vld_q || (bus.value != cap_val_q) || (bus.hex_mode != cap_hex_q)) begin
               cap_val_d = bus.value;
               cap_hex_d = bus.hex_mode;
               sh_d      = bus.value;
               acc_d     = '0;
               cnt_d     = '0;
               busy_d    = 1'b1;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cap_hex_q) begin
               acc_d   = ACC_W'(cap_val_q);
               state_d = ST_COMMIT;
            end else begin
               acc_d = {adj[ACC_W-2:0], sh_q[VALUE_W-1]};
               sh_d  = {sh_q[VALUE_W-2:0], 1'b0};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            num_d   = acc_q[NDA*4-1:0];
            vld_d   = 1'b1;
            busy_d  = 1'b0;
            ovf_d   = cap_hex_q ? (64'(cap_val_q) >= HEX_LIM) : (64'(cap_val_q) >= DEC_LIM);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Scan divider, blink phase, and the glyph for the digit currently selected.
   always_comb begin
      div_d   = div_q + 1'b1;
      dig_d   = dig_q;
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
         div_d = '0;
         dig_d = (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
      end
      blk_d   = blk_q + 1'b1;
      phase_d = phase_q;
      if (blk_q == BLK_W'(BLINK_DIV - 1)) begin
         blk_d   = '0;
         phase_d = ~phase_q;
      end

      // keep[i]: some digit at position i or higher is non-zero
      any_nz = 1'b0;
      keep   = '0;
      for (int i = NDA - 1; i >= 0; i--) begin
         any_nz  = any_nz | (num_q[i*4 +: 4] != 4'd0);
         keep[i] = any_nz;
      end

      nib = 4'd0;
      kp  = 1'b0;
      for (int i = 0; i < NDA; i++) begin
         if (dig_q == DIG_W'(i)) begin
            nib = num_q[i*4 +: 4];
            kp  = keep[i] || (i == 0);
         end
      end

      is_tag = 1'b0;
      tag_g  = 7'h7F;
      if (TAG_EN != 0) begin
         for (int i = 0; i < 4; i++) begin
            if (dig_q == DIG_W'(ND + i)) begin
               is_tag = 1'b1;
               tag_g  = tag_glyph(i);
            end
         end
      end

      if (is_tag)                    glyph = tag_g;
      else if (!vld_q)               glyph = 7'h7F;
      else if (ovf_q)                glyph = 7'h3F;
      else if (bus.blank_lz && !kp)  glyph = 7'h7F;
      else                           glyph = hex_glyph(nib);

      led_d = (!bus.ena || (bus.blink && phase_q)) ? 7'h7F : glyph;
      sel_d = ~(NUM_DIGITS'(1) << dig_q);
   end

   // All state registers, cleared asynchronously.
   always_ff @(posedge clk100mhz or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cap_val_q <= '0;
         cap_hex_q <= 1'b0;
         sh_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
         num_q     <= '0;
         vld_q     <= 1'b0;
         div_q     <= '0;
         dig_q     <= '0;
         blk_q     <= '0;
         phase_q   <= 1'b0;
         led_q     <= 7'h7F;
         sel_q     <= '1;
      end else begin
         state_q   <= state_d;
         cap_val_q <= cap_val_d;
         cap_hex_q <= cap_hex_d;
         sh_q      <= sh_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
         num_q     <= num_d;
         vld_q     <= vld_d;
         div_q     <= div_d;
         dig_q     <= dig_d;
         blk_q     <= blk_d;
         phase_q   <= phase_d;
         led_q     <= led_d;
         sel_q     <= sel_d;
      end
   end

   assign bus.seg_LED    = led_q;
   assign bus.seg_select = sel_q;
   assign bus.busy       = busy_q;
   assign bus.overflow   = ovf_q;
   assign bus.conv_state = state_q;

endmodule
